spi_adc_fifo_wrapper: RTL and testbench
=======================================

// Module: spi_adc_fifo_wrapper
// PURPOSE
//  Top-level SPI ADC front end. Runs a 16-bit SPI read from a serial ADC
//  (master drives cs_n/sclk, captures din1) and splits each sample into two
//  bytes, high byte first. The bytes go into an on-chip 8-bit synchronous FIFO
//  that downstream logic drains with fifo_pop.
// PARAMETERS
//  CLK_DIV     2   clk cycles per sclk half-period (sclk = clk/(2*CLK_DIV)); >=1
//  FIFO_DEPTH  16  FIFO entries (bytes), power of 2, >=2
// PORTS
//  clk           in   1  system clock; all logic on rising edge
//  rst           in   1  synchronous, active-high reset
//  start_sample  in   1  conversion request; rising edge (registered) starts one conversion
//  din1          in   1  ADC serial data, MSB first
//  fifo_pop      in   1  read strobe, one byte per cycle while high
//  cs_n          out  1  ADC chip select, active low
//  sclk          out  1  SPI clock, idles low
//  ready         out  1  high when FSM is in IDLE
//  done          out  1  one-cycle pulse: both bytes of a sample are in the FIFO
//  fifo_dout     out  8  registered read data
//  fifo_empty    out  1  FIFO holds 0 bytes
//  fifo_full     out  1  FIFO holds FIFO_DEPTH bytes
// BEHAVIOUR
//  Reset: state=IDLE, cs_n=1, sclk=0, done=0, fifo_dout=0, FIFO pointers/count
//   cleared (fifo_empty=1, fifo_full=0). ready=1 (IDLE). Reset mid-conversion
//   aborts at once and discards the partial sample.
//  FSM: IDLE -> SAMPLE -> WRITE_HI -> WRITE_LO -> DONE -> IDLE.
//   IDLE: cs_n=1, sclk=0. A start_sample 0->1 edge (previous-cycle register)
//    moves to SAMPLE next cycle. A level held high does not retrigger.
//   SAMPLE: cs_n=0. Divider counts 0..CLK_DIV-1; at terminal count sclk toggles.
//    First toggle is rising. On each falling toggle, shift din1 into the LSB of a
//    16-bit shift register (shreg <= {shreg[14:0],din1}). After the 16th falling
//    edge, sclk is low; go to WRITE_HI and set cs_n=1.
//    Duration = 32*CLK_DIV clk cycles.
//   WRITE_HI: push shreg[15:8]. WRITE_LO: push shreg[7:0].
//   DONE: done=1 for exactly this cycle. Both pushes are already visible
//    (fifo_empty=0). Then IDLE.
//  The ADC drives din1 after each sclk rising edge; the master samples on falling edges.
//  FIFO: circular buffer with log2(FIFO_DEPTH)-bit pointers that wrap, and a
//   count of log2(FIFO_DEPTH)+1 bits.
//   Push when full: byte dropped, state unchanged. Each byte checked independently.
//   Pop when !empty: fifo_dout <= mem[rd_ptr] next edge, rd_ptr++.
//   Pop when empty: ignored, fifo_dout holds its value.
//   Push and pop in the same cycle: both performed, count unchanged.
//    If empty, only the push occurs. If full, the pop occurs and the push is also
//    accepted, because a slot frees in that cycle.
//   fifo_empty/fifo_full come from count and are registered-state accurate every cycle.
// STRUCTURE
//  Package spi_adc_pkg: state enum (IDLE, SAMPLE, WRITE_HI, WRITE_LO, DONE),
//   SAMPLE_BITS=16, BYTE_W=8.
//  One sub-module spi_adc_capture, instance u_spi_adc: FSM, divider, shift
//   register, cs_n/sclk/ready/done, push strobe + data. Exposes internal
//   signal `state` of the package enum type.
//  FIFO is inline in the top.
// TESTING
//  1 Reset held 2 cycles -> cs_n=1, sclk=0, ready=1, done=0, fifo_empty=1,
//    fifo_full=0, fifo_dout=0.
//  2 Start edge, ADC streams 0xABCD MSB first -> exactly 16 sclk pulses with
//    cs_n low; one done pulse. Two pops give fifo_dout=0xAB then 0xCD;
//    fifo_empty=1 after the second pop.
//  3 Pop while empty -> fifo_dout unchanged, empty stays 1. start_sample held high
//    after a conversion -> no second conversion.
//  4 Eight conversions (0x0102..0x0F10), depth 16 -> fifo_full=1. A ninth
//    conversion is dropped. Sixteen pops return 01,02,...,0F,10 in order.
//  5 Reset asserted mid-SAMPLE (after 7 bits) -> next cycle cs_n=1, sclk=0,
//    ready=1, fifo_empty=1, no done.
//  6 Pop one byte in the same cycle as WRITE_LO with one byte stored ->
//    count unchanged (1), data order preserved.

Source files
------------

// File: rtl/spi_adc_pkg.sv
// Shared types and constants for the SPI ADC front end.
package spi_adc_pkg;

  localparam int SAMPLE_BITS = 16;
  localparam int BYTE_W      = 8;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    WRITE_HI,
    WRITE_LO,
    DONE
  } state_t;

endpackage

// File: rtl/spi_adc_if.sv
// Bundles the SPI pins, conversion control and FIFO read port of the ADC front end.
interface spi_adc_if;
  import spi_adc_pkg::*;

  logic              start_sample;
  logic              din1;
  logic              fifo_pop;
  logic              cs_n;
  logic              sclk;
  logic              ready;
  logic              done;
  logic [BYTE_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              fifo_full;

  // Front-end side: drives the SPI pins and the FIFO read outputs.
  modport master (
    input  start_sample, din1, fifo_pop,
    output cs_n, sclk, ready, done, fifo_dout, fifo_empty, fifo_full
  );

  // Environment side: ADC plus downstream consumer.
  modport slave (
    output start_sample, din1, fifo_pop,
    input  cs_n, sclk, ready, done, fifo_dout, fifo_empty, fifo_full
  );

endinterface

// File: rtl/spi_adc_capture.sv
// SPI master that reads one 16-bit ADC sample per start edge and emits it as
// two byte pushes, high byte first.
module spi_adc_capture
  import spi_adc_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_sample_i,
  input  logic              din1_i,
  output logic              cs_n_o,
  output logic              sclk_o,
  output logic              ready_o,
  output logic              done_o,
  output logic              push_o,
  output logic [BYTE_W-1:0] push_data_o
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BCNT_W = $clog2(SAMPLE_BITS);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(SAMPLE_BITS - 1);

  state_t                 state;
  logic [DIV_W-1:0]       div_q;
  logic [BCNT_W-1:0]      bit_cnt_q;
  logic [SAMPLE_BITS-1:0] shreg_q;
  logic                   start_prev_q;
  logic                   cs_n_q;
  logic                   sclk_q;
  logic                   ready_q;
  logic                   done_q;

  logic div_tc;
  logic fall_tick;

  assign div_tc    = (div_q == DIV_LAST);
  // sclk is high and about to toggle: this edge is a falling sclk edge.
  assign fall_tick = (state == SAMPLE) && div_tc && sclk_q;

  // Conversion FSM with sclk divider and registered pin/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      div_q        <= '0;
      bit_cnt_q    <= '0;
      start_prev_q <= 1'b0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      start_prev_q <= start_sample_i;
      done_q       <= 1'b0;
      case (state)
        IDLE: begin
          if (start_sample_i && !start_prev_q) begin
            state     <= SAMPLE;
            cs_n_q    <= 1'b0;
            ready_q   <= 1'b0;
            div_q     <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
          end
        end
        SAMPLE: begin
          if (div_tc) begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
            if (sclk_q) begin
              bit_cnt_q <= bit_cnt_q + BCNT_W'(1);
              if (bit_cnt_q == BIT_LAST) begin
                state  <= WRITE_HI;
                cs_n_q <= 1'b1;
              end
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        WRITE_HI: state <= WRITE_LO;
        WRITE_LO: begin
          state  <= DONE;
          done_q <= 1'b1;
        end
        DONE: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift in din1 on every falling sclk edge; a partial sample is simply overwritten next time.
  always_ff @(posedge clk) begin
    if (fall_tick) shreg_q <= {shreg_q[SAMPLE_BITS-2:0], din1_i};
  end

  assign push_o      = (state == WRITE_HI) || (state == WRITE_LO);
  assign push_data_o = (state == WRITE_HI) ? shreg_q[SAMPLE_BITS-1:BYTE_W] : shreg_q[BYTE_W-1:0];

  assign cs_n_o  = cs_n_q;
  assign sclk_o  = sclk_q;
  assign ready_o = ready_q;
  assign done_o  = done_q;

endmodule

// File: rtl/spi_adc_fifo_wrapper.sv
// SPI ADC front end: capture engine feeding an inline byte FIFO drained by fifo_pop.
module spi_adc_fifo_wrapper
  import spi_adc_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  spi_adc_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic              push;
  logic [BYTE_W-1:0] push_data;

  spi_adc_capture #(.CLK_DIV(CLK_DIV)) u_spi_adc (
    .clk            (clk),
    .rst            (rst),
    .start_sample_i (bus.start_sample),
    .din1_i         (bus.din1),
    .cs_n_o         (bus.cs_n),
    .sclk_o         (bus.sclk),
    .ready_o        (bus.ready),
    .done_o         (bus.done),
    .push_o         (push),
    .push_data_o    (push_data)
  );

  logic [BYTE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic [PTR_W:0]    count_d;
  logic [BYTE_W-1:0] dout_q;
  logic              pop_en;
  logic              push_en;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted alongside it.
  assign pop_en  = bus.fifo_pop && (count_q != '0);
  assign push_en = push && ((count_q != FULL_CNT) || pop_en);

  // Occupancy follows accepted pushes and pops; simultaneous ones cancel.
  always_comb begin
    count_d = count_q;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers, occupancy and the registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      count_q <= count_d;
      if (push_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        dout_q   <= mem_q[rd_ptr_q];
      end
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

  assign bus.fifo_dout  = dout_q;
  assign bus.fifo_empty = (count_q == '0);
  assign bus.fifo_full  = (count_q == FULL_CNT);

endmodule

// File: tb/tb_spi_adc_fifo_wrapper.sv
// Bench for spi_adc_fifo_wrapper: ADC serial model, byte-queue reference model
// of the FIFO, and one task per scenario.
module tb_spi_adc_fifo_wrapper;

  localparam int CLK_DIV = 2;
  localparam int DEPTH   = 16;
  localparam int BUDGET  = 32 * CLK_DIV + 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_adc_if ifc ();

  spi_adc_fifo_wrapper #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  model_q[$];
  logic [7:0]  last_dout = 8'h00;
  logic [15:0] adc_word  = 16'h0000;

  int   rise_cnt = 0, fall_cnt = 0, done_cnt = 0, cs_low_cnt = 0;
  logic sclk_prev = 1'b0;

  // Activity monitor, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (ifc.sclk && !sclk_prev && !ifc.cs_n) rise_cnt++;
      if (!ifc.sclk && sclk_prev) fall_cnt++;
      if (ifc.done) done_cnt++;
      if (!ifc.cs_n) cs_low_cnt++;
      sclk_prev = ifc.sclk;
    end
  end

  // ADC model: presents the next bit MSB first shortly after each sclk rise.
  initial begin
    int bit_i;
    forever begin
      @(negedge ifc.cs_n);
      bit_i = 15;
      while (bit_i >= 0) begin
        @(posedge ifc.sclk or posedge ifc.cs_n);
        if (ifc.cs_n) break;
        #1 ifc.din1 = adc_word[bit_i];
        bit_i--;
      end
    end
  end

  task automatic model_reset();
    model_q.delete();
    last_dout = 8'h00;
  endtask

  task automatic model_push(input logic [7:0] b);
    if (model_q.size() < DEPTH) model_q.push_back(b);
  endtask

  // One conversion; optionally leaves start_sample high afterwards.
  task automatic conv(input logic [15:0] w, input bit hold);
    bit seen = 0;
    adc_word = w;
    ifc.start_sample = 1'b1;
    @(negedge clk);
    if (!hold) ifc.start_sample = 1'b0;
    for (int n = 0; n < BUDGET; n++) begin
      @(negedge clk);
      if (ifc.done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL conv_done: got no done within %0d cycles, required a done pulse (word %h)", BUDGET, w);
    end
    model_push(w[15:8]);
    model_push(w[7:0]);
    checks++;
    if (ifc.fifo_empty !== (model_q.size() == 0) || ifc.fifo_full !== (model_q.size() == DEPTH)) begin
      errors++;
      $display("FAIL conv_flags: got empty=%b full=%b, required empty=%b full=%b",
               ifc.fifo_empty, ifc.fifo_full, model_q.size() == 0, model_q.size() == DEPTH);
    end
    @(negedge clk);
    checks++;
    if (ifc.done !== 1'b0) begin
      errors++;
      $display("FAIL done_width: got done=%b one cycle later, required 0", ifc.done);
    end
  endtask

  // One pop, compared against the reference queue.
  task automatic pop_check(input string name);
    logic [7:0] exp;
    if (model_q.size() > 0) exp = model_q.pop_front();
    else exp = last_dout;
    last_dout = exp;
    ifc.fifo_pop = 1'b1;
    @(negedge clk);
    ifc.fifo_pop = 1'b0;
    checks++;
    if (ifc.fifo_dout !== exp || ifc.fifo_empty !== (model_q.size() == 0)) begin
      errors++;
      $display("FAIL %s: got dout=%h empty=%b, required dout=%h empty=%b",
               name, ifc.fifo_dout, ifc.fifo_empty, exp, model_q.size() == 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ifc.cs_n, ifc.sclk, ifc.ready, ifc.done, ifc.fifo_empty, ifc.fifo_full} !== 6'b101010) begin
      errors++;
      $display("FAIL reset_ctrl: got cs_n,sclk,ready,done,empty,full=%b, required 101010",
               {ifc.cs_n, ifc.sclk, ifc.ready, ifc.done, ifc.fifo_empty, ifc.fifo_full});
    end
    checks++;
    if (ifc.fifo_dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_dout: got %h, required 00", ifc.fifo_dout);
    end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_single();
    int r0 = rise_cnt, d0 = done_cnt, c0 = cs_low_cnt;
    conv(16'hABCD, 0);
    checks++;
    if (rise_cnt - r0 != 16) begin
      errors++;
      $display("FAIL sclk_pulses: got %0d, required 16", rise_cnt - r0);
    end
    checks++;
    if (cs_low_cnt - c0 != 32 * CLK_DIV) begin
      errors++;
      $display("FAIL cs_low_cycles: got %0d, required %0d", cs_low_cnt - c0, 32 * CLK_DIV);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL done_count: got %0d, required 1", done_cnt - d0);
    end
    checks++;
    if (ifc.ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after: got %b, required 1", ifc.ready);
    end
    pop_check("pop_hi_AB");
    checks++;
    if (last_dout !== 8'hAB) begin
      errors++;
      $display("FAIL model_AB: got %h, required AB", last_dout);
    end
    pop_check("pop_lo_CD");
  endtask

  task automatic test_pop_empty_and_hold();
    int d0, r0;
    pop_check("pop_empty");
    d0 = done_cnt;
    r0 = rise_cnt;
    conv(16'($urandom), 1);
    repeat (200) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || rise_cnt - r0 != 16) begin
      errors++;
      $display("FAIL hold_retrigger: got done=%0d pulses=%0d, required done=1 pulses=16",
               done_cnt - d0, rise_cnt - r0);
    end
    ifc.start_sample = 1'b0;
    @(negedge clk);
    pop_check("hold_pop0");
    pop_check("hold_pop1");
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) conv({8'(2 * i + 1), 8'(2 * i + 2)}, 0);
    checks++;
    if (ifc.fifo_full !== 1'b1) begin
      errors++;
      $display("FAIL fill_full: got %b, required 1", ifc.fifo_full);
    end
    conv(16'($urandom), 0);
    checks++;
    if (ifc.fifo_full !== 1'b1 || model_q.size() != DEPTH) begin
      errors++;
      $display("FAIL ninth_dropped: got full=%b, required 1", ifc.fifo_full);
    end
    for (int i = 0; i < 16; i++) begin
      pop_check("fill_pop");
      checks++;
      if (ifc.fifo_dout !== 8'(i + 1)) begin
        errors++;
        $display("FAIL fill_order: got %h, required %h", ifc.fifo_dout, 8'(i + 1));
      end
    end
  endtask

  task automatic test_reset_mid();
    int f0, d0;
    bit reached = 0;
    conv(16'h1234, 0);
    adc_word = 16'($urandom);
    f0 = fall_cnt;
    ifc.start_sample = 1'b1;
    @(negedge clk);
    ifc.start_sample = 1'b0;
    for (int n = 0; n < BUDGET; n++) begin
      @(negedge clk);
      if (fall_cnt - f0 >= 7) begin
        reached = 1;
        break;
      end
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL mid_wait: got %0d falling edges, required 7", fall_cnt - f0);
    end
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ifc.cs_n, ifc.sclk, ifc.ready, ifc.fifo_empty, ifc.done} !== 5'b10110) begin
      errors++;
      $display("FAIL mid_reset: got cs_n,sclk,ready,empty,done=%b, required 10110",
               {ifc.cs_n, ifc.sclk, ifc.ready, ifc.fifo_empty, ifc.done});
    end
    rst = 1'b0;
    model_reset();
    repeat (100) @(negedge clk);
    checks++;
    if (done_cnt != d0 || ifc.cs_n !== 1'b1 || ifc.fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL mid_abort: got done_pulses=%0d cs_n=%b empty=%b, required 0 1 1",
               done_cnt - d0, ifc.cs_n, ifc.fifo_empty);
    end
  endtask

  task automatic test_pop_same_cycle();
    logic [15:0] w = 16'($urandom);
    logic [7:0]  exp;
    bit seen_low = 0, seen_hi = 0;
    adc_word = w;
    ifc.start_sample = 1'b1;
    @(negedge clk);
    ifc.start_sample = 1'b0;
    for (int n = 0; n < BUDGET; n++) begin
      @(negedge clk);
      if (seen_low && ifc.cs_n) begin
        seen_hi = 1;
        break;
      end
      if (!ifc.cs_n) seen_low = 1;
    end
    checks++;
    if (!seen_hi) begin
      errors++;
      $display("FAIL same_wait: got no cs_n release, required one");
    end
    @(negedge clk);
    ifc.fifo_pop = 1'b1;
    @(negedge clk);
    ifc.fifo_pop = 1'b0;
    model_q.push_back(w[15:8]);
    exp = model_q.pop_front();
    model_q.push_back(w[7:0]);
    last_dout = exp;
    checks++;
    if (ifc.done !== 1'b1 || ifc.fifo_dout !== exp || ifc.fifo_empty !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle: got done=%b dout=%h empty=%b, required 1 %h 0",
               ifc.done, ifc.fifo_dout, ifc.fifo_empty, exp);
    end
    @(negedge clk);
    pop_check("same_pop_lo");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      conv(16'($urandom), 0);
      repeat ($urandom_range(0, 3)) pop_check("rand_pop");
    end
    while (model_q.size() > 0) pop_check("rand_drain");
    pop_check("rand_empty");
  endtask

  initial begin
    ifc.start_sample = 1'b0;
    ifc.din1         = 1'b0;
    ifc.fifo_pop     = 1'b0;
    test_reset();
    test_single();
    test_pop_empty_and_hold();
    test_fill();
    test_reset_mid();
    test_pop_same_cycle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
